// File: rtl/dsp_pkg.sv
// Shared types and PRBS9 constants for the PRBS9 receive checker.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } rx_state_t;

  // x^9 + x^5 + 1
  localparam int unsigned PRBS9_LEN   = 9;
  localparam int unsigned PRBS9_TAP_A = 9;
  localparam int unsigned PRBS9_TAP_B = 5;

endpackage

// File: rtl/prbs9_predictor.sv
// PRBS9 self-synchronising predictor: 9-bit history with a selectable shift
// input (received bit while acquiring, own prediction once locked).
module prbs9_predictor
  import dsp_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_shift,
  input  logic i_use_pred,
  input  logic i_rx_bit,
  output logic o_pred
);

  logic [PRBS9_LEN-1:0] s;
  logic                 shift_in;

  assign o_pred   = s[PRBS9_TAP_A-1] ^ s[PRBS9_TAP_B-1];
  assign shift_in = i_use_pred ? o_pred : i_rx_bit;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      s <= '0;
    end else if (i_shift) begin
      s <= {s[PRBS9_LEN-2:0], shift_in};
    end
  end

endmodule

// File: rtl/prbs9_rx_checker.sv
// PRBS9 receive checker: phase pick, hard slice, self-sync lock FSM and BER
// counters. Define PRBS9_RX_LOL_EN to enable the windowed loss-of-lock monitor.
module prbs9_rx_checker
  import dsp_pkg::*;
#(
  parameter int unsigned NB_INPUT     = 8,
  parameter int unsigned N_PHASES     = 4,
  parameter int unsigned NB_PHASE_SEL = 2,
  parameter int unsigned LOCK_LEN     = 32,
  parameter int unsigned NB_BER_CNT   = 64,
  parameter int unsigned LOL_WIN      = 64,
  parameter int unsigned LOL_THR      = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic [NB_INPUT-1:0]     i_data,
  input  logic                    i_valid,
  input  logic                    i_en,
  input  logic [NB_PHASE_SEL-1:0] i_phase_sel,
  output logic                    o_lock,
  output logic [NB_BER_CNT-1:0]   o_ber_samp,
  output logic [NB_BER_CNT-1:0]   o_ber_error,
  output logic                    o_ber_zero
);

  localparam int unsigned NB_MATCH = $clog2(LOCK_LEN + 1);

  rx_state_t               state;
  logic [NB_PHASE_SEL-1:0] phase_q;
  logic [NB_PHASE_SEL-1:0] phase_cur;
  logic [3:0]              fill_cnt;
  logic [NB_MATCH-1:0]     match_cnt;
  logic                    strobe;
  logic                    rx_bit;
  logic                    pred;
  logic                    mismatch;
  logic                    unused_data;

`ifdef PRBS9_RX_LOL_EN
  localparam int unsigned NB_WIN  = (LOL_WIN > 1) ? $clog2(LOL_WIN) : 1;
  localparam int unsigned NB_WERR = $clog2(LOL_THR + 1);
  logic [NB_WIN-1:0]  win_cnt;
  logic [NB_WERR-1:0] win_err;
`else
  localparam int unsigned unused_lol_cfg = LOL_WIN + LOL_THR;
`endif

  // Index of the current sample within the symbol; a strobe restarts it.
  always_comb begin
    if (i_valid) begin
      phase_cur = '0;
    end else if (phase_q == NB_PHASE_SEL'(N_PHASES - 1)) begin
      phase_cur = phase_q;
    end else begin
      phase_cur = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_cur;
    end
  end

  assign strobe      = i_en && (phase_cur == i_phase_sel);
  assign rx_bit      = i_data[NB_INPUT-1];
  assign mismatch    = pred ^ rx_bit;
  assign unused_data = ^i_data[NB_INPUT-2:0];

  prbs9_predictor u_pred (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_shift    (strobe && (state != ST_IDLE)),
    .i_use_pred (state == ST_LOCKED),
    .i_rx_bit   (rx_bit),
    .o_pred     (pred)
  );

  // o_ber_zero is tracked alongside every write of o_lock/o_ber_error so it
  // stays a true register rather than a decode of the counter.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      o_lock      <= 1'b0;
      o_ber_samp  <= '0;
      o_ber_error <= '0;
      o_ber_zero  <= 1'b0;
`ifdef PRBS9_RX_LOL_EN
      win_cnt     <= '0;
      win_err     <= '0;
`endif
    end else if (!i_en) begin
      state      <= ST_IDLE;
      o_lock     <= 1'b0;
      o_ber_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_HUNT;
          fill_cnt <= '0;
        end
        ST_HUNT: begin
          if (strobe) begin
            if (fill_cnt == 4'(PRBS9_LEN - 1)) begin
              state     <= ST_VERIFY;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (strobe) begin
            if (mismatch) begin
              state    <= ST_HUNT;
              fill_cnt <= '0;
            end else if (match_cnt == NB_MATCH'(LOCK_LEN - 1)) begin
              state       <= ST_LOCKED;
              o_lock      <= 1'b1;
              o_ber_samp  <= '0;
              o_ber_error <= '0;
              o_ber_zero  <= 1'b1;
`ifdef PRBS9_RX_LOL_EN
              win_cnt     <= '0;
              win_err     <= '0;
`endif
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (strobe) begin
            if (o_ber_samp != '1) begin
              o_ber_samp <= o_ber_samp + 1'b1;
            end
            if (mismatch) begin
              if (o_ber_error != '1) begin
                o_ber_error <= o_ber_error + 1'b1;
              end
              o_ber_zero <= 1'b0;
            end
`ifdef PRBS9_RX_LOL_EN
            if (mismatch && (win_err == NB_WERR'(LOL_THR - 1))) begin
              state    <= ST_HUNT;
              fill_cnt <= '0;
              o_lock   <= 1'b0;
            end
            if (win_cnt == NB_WIN'(LOL_WIN - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err + NB_WERR'(mismatch);
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs9_rx_checker.sv
// Self-checking bench for prbs9_rx_checker: PRBS9 source model with injected
// sign flips; expected lock timing and BER counts derived from symbol counts.
module tb_prbs9_rx_checker;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_en;
  logic [1:0] i_phase_sel;

  logic        lock_a, zero_a;
  logic [63:0] samp_a, err_a;
  logic        lock_b, zero_b;
  logic [7:0]  samp_b, err_b;

  int n_pass = 0;
  int n_chk  = 0;

  bit       hist[$];
  logic [8:0] seed_q;

  always #5 clk = ~clk;

  prbs9_rx_checker #(
    .NB_INPUT(8), .N_PHASES(4), .NB_PHASE_SEL(2), .LOCK_LEN(32),
    .NB_BER_CNT(64), .LOL_WIN(64), .LOL_THR(8)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_en(i_en), .i_phase_sel(i_phase_sel), .o_lock(lock_a),
    .o_ber_samp(samp_a), .o_ber_error(err_a), .o_ber_zero(zero_a)
  );

  prbs9_rx_checker #(
    .NB_INPUT(8), .N_PHASES(4), .NB_PHASE_SEL(2), .LOCK_LEN(32),
    .NB_BER_CNT(8), .LOL_WIN(64), .LOL_THR(8)
  ) dut8 (
    .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_en(i_en), .i_phase_sel(i_phase_sel), .o_lock(lock_b),
    .o_ber_samp(samp_b), .o_ber_error(err_b), .o_ber_zero(zero_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic new_seed(input logic [8:0] seed);
    hist.delete();
    seed_q = seed;
  endtask

  // Source bit n: seed bits first (MSB first), then b[n] = b[n-9] ^ b[n-5].
  task automatic gen_bit(output bit b);
    int n = hist.size();
    if (n < 9) b = seed_q[8-n];
    else       b = hist[n-9] ^ hist[n-5];
    hist.push_back(b);
  endtask

  task automatic send_sym(input bit flip);
    bit b;
    gen_bit(b);
    for (int p = 0; p < 4; p++) begin
      i_valid = (p == 0);
      i_data  = (b ^ flip) ? 8'hC0 : 8'h40;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int k = 0; k < n; k++) send_sym(1'b0);
  endtask

  // Disabled gap, then one enabled cycle so the FSM is hunting at the next symbol.
  task automatic gap_then_enable(input int n);
    i_en = 1'b0;
    i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    i_en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int         k;
    int         last;
    int         nflip;
    logic [63:0] mask;

    i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_data = 8'h40; i_phase_sel = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", 64'(lock_a), 64'd0);
    chk("rst_samp", samp_a, 64'd0);
    chk("rst_err",  err_a,  64'd0);
    chk("rst_zero", 64'(zero_a), 64'd0);
    i_rst = 1'b0;

    // Clean lock, seed 0x1AA, phase 2
    new_seed(9'h1AA);
    gap_then_enable(2);
    send_n(40);
    chk("clean_nolock_40", 64'(lock_a), 64'd0);
    send_n(1);
    chk("clean_lock_41", 64'(lock_a), 64'd1);
    chk("clean_samp0", samp_a, 64'd0);
    chk("clean_zero0", 64'(zero_a), 64'd1);
    send_n(511);
    chk("clean_samp511", samp_a, 64'd511);
    chk("clean_err0", err_a, 64'd0);
    chk("clean_zero", 64'(zero_a), 64'd1);
    chk("sat_samp255", 64'(samp_b), 64'd255);
    chk("sat_err0", 64'(err_b), 64'd0);

    // Single error while locked, random position and sampling phases
    k = $urandom_range(0, 99);
    for (int i = 0; i < 100; i++) begin
      i_phase_sel = 2'($urandom_range(0, 3));
      send_sym(i == k);
      if (i == k) chk("single_err_now", err_a, 64'd1);
    end
    chk("single_err_total", err_a, 64'd1);
    chk("single_lock", 64'(lock_a), 64'd1);
    chk("single_zero", 64'(zero_a), 64'd0);
    chk("single_samp", samp_a, 64'd611);
    chk("single_sat_samp", 64'(samp_b), 64'd255);

    // Drop enable mid-lock
    i_en = 1'b0;
    @(posedge clk); #1;
    chk("dis_lock", 64'(lock_a), 64'd0);
    chk("dis_zero", 64'(zero_a), 64'd0);
    chk("dis_samp", samp_a, 64'd611);
    chk("dis_err",  err_a,  64'd1);

    // Re-enable with a fresh random stream; error on the 20th strobe (VERIFY)
    new_seed(9'($urandom_range(1, 511)));
    i_phase_sel = 2'($urandom_range(0, 3));
    gap_then_enable(3);
    for (int i = 0; i < 20; i++) send_sym(i == 19);
    send_n(40);
    chk("verify_nolock", 64'(lock_a), 64'd0);
    chk("verify_frozen_samp", samp_a, 64'd611);
    send_n(1);
    chk("verify_relock", 64'(lock_a), 64'd1);
    chk("relock_samp_clr", samp_a, 64'd0);
    chk("relock_err_clr", err_a, 64'd0);
    chk("relock_zero", 64'(zero_a), 64'd1);

    // Eight errors inside one 64-symbol window
    mask = '0;
    nflip = 0;
    while (nflip < 8) begin
      k = $urandom_range(0, 63);
      if (!mask[k]) begin mask[k] = 1'b1; nflip++; end
    end
    last = 0;
    for (int i = 0; i < 64; i++) if (mask[i]) last = i;
`ifdef PRBS9_RX_LOL_EN
    for (int i = 0; i <= last; i++) send_sym(mask[i]);
    chk("lol_drop", 64'(lock_a), 64'd0);
    chk("lol_err_hold", err_a, 64'd8);
    chk("lol_samp_hold", samp_a, 64'(last + 1));
    send_n(40);
    chk("lol_nolock_40", 64'(lock_a), 64'd0);
    send_n(1);
    chk("lol_relock", 64'(lock_a), 64'd1);
    chk("lol_relock_err", err_a, 64'd0);
`else
    for (int i = 0; i < 64; i++) send_sym(mask[i]);
    chk("nolol_lock", 64'(lock_a), 64'd1);
    chk("nolol_err", err_a, 64'd8);
    chk("nolol_samp", samp_a, 64'd64);
    chk("nolol_zero", 64'(zero_a), 64'd0);
    chk("nolol_err8b", 64'(err_b), 64'd8);
`endif

    // Reset coincident with a strobe
    i_phase_sel = 2'($urandom_range(0, 3));
    for (int p = 0; p < 4; p++) begin
      i_valid = (p == 0);
      i_rst   = (p == int'(i_phase_sel));
      @(posedge clk); #1;
      if (p == int'(i_phase_sel)) begin
        chk("rst_strobe_lock", 64'(lock_a), 64'd0);
        chk("rst_strobe_samp", samp_a, 64'd0);
        chk("rst_strobe_err",  err_a,  64'd0);
        chk("rst_strobe_zero", 64'(zero_a), 64'd0);
        chk("rst_strobe_samp8", 64'(samp_b), 64'd0);
      end
    end
    i_rst = 1'b0;
    i_valid = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
